seg_display_scanner: RTL
========================

// Module: seg_display_scanner
// PURPOSE
//   Time-multiplexes a 4-digit BCD value onto a common-anode 4-digit 7-segment display.
//   Sits directly upstream of hexto7segment: drives its 4-bit digit input and the matching
//   active-low anode/decimal-point lines. Never presents a nibble above 9 to the decoder.
//   New values are loaded through a shadow register and applied only at frame boundaries,
//   so a displayed frame never tears.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (must be >= 2; 100 MHz -> 1 kHz/digit)
//   BLANK_CYC    500     cycles at the start of each slot with all anodes off (< REFRESH_DIV)
// PORTS
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   load       in   1   1-cycle strobe: capture value/dp_in into the shadow register
//   value      in   16  four BCD nibbles; [3:0] = digit0 (rightmost) ... [15:12] = digit3
//   dp_in      in   4   decimal-point enables, 1 = lit; bit i maps to digit i
//   blank_lz   in   1   1 = blank leading zeros on digits 3..1 (level, sampled every cycle)
//   digit      out  4   BCD nibble for hexto7segment.x, always in 0..9
//   an         out  4   anode enables, active-low, at most one bit low
//   dp         out  1   decimal point, active-low
//   frame_done out  1   1-cycle pulse when slot index wraps 3 -> 0
//   bcd_err    out  1   1 = the active display value contains a nibble > 9
// BEHAVIOUR
//   Reset (async assert, sync release): prescaler=0, idx=0, shadow=0, disp=0, pending=0,
//     an=4'b1111, digit=0, dp=1, frame_done=0, bcd_err=0.
//   Prescaler: counts 0..REFRESH_DIV-1, then wraps. tick = (count == REFRESH_DIV-1).
//   Slot index idx (2 bits): increments on tick, 3 -> 0 wrap. frame_done=1 in the cycle after
//     the tick with idx==3.
//   Load: when load=1, shadow <= {value,dp_in} and pending <= 1. Back-to-back loads: last wins.
//   Frame boundary (tick && idx==3): if pending, disp <= shadow and pending <= 0.
//     A load in the same cycle as the boundary: disp takes the previous shadow contents;
//     the new value goes to shadow and pending stays 1 (applied at the next boundary).
//   bcd_err: recomputed whenever disp updates; 1 iff any disp nibble > 9.
//   Outputs are registered, with 1-cycle latency from the prescaler/idx state:
//     - During slot cycles with count < BLANK_CYC: an = 4'b1111, dp = 1; digit keeps
//       the new slot's nibble.
//     - Otherwise: an = ~(4'b0001 << idx), digit = disp nibble[idx], dp = ~disp_dp[idx].
//   Invalid nibble (> 9) in the active slot: digit = 0, and the anode stays off for that slot.
//   Leading-zero blanking (blank_lz=1): digit i (i=3..1) is blanked (anode off, dp still
//     honoured) if nibble i and all higher nibbles are 0. Digit0 is never blanked.
//   Async reset mid-frame: all outputs return to reset values immediately; the pending
//     load is discarded.
// TESTING  (REFRESH_DIV=4, BLANK_CYC=1 unless stated)
//   1 Reset, no load -> an cycles 1110/1101/1011/0111 (each after a 1-cycle 1111 gap);
//     digit=0 in every slot; frame_done pulses once every 16 cycles.
//   2 load value=16'h1234 mid-frame -> display unchanged until the next frame boundary;
//     from the following frame, slot0 digit=4, slot1 digit=3, slot2 digit=2, slot3 digit=1.
//   3 value=16'h0042, blank_lz=1 -> slots 3 and 2 show an=1111; slots 1 and 0 show 4 and 2.
//     With blank_lz=0 -> all four anodes are driven, digits 0,0,4,2.
//   4 load 16'h00A5 -> bcd_err=1 after the boundary; slot1 has an=1111 and digit=0;
//     a later load of 16'h0005 clears bcd_err at the next boundary.
//   5 load asserted exactly on the boundary tick with value=16'h9999 (shadow=16'h1111)
//     -> the next frame shows 1111, the frame after that shows 9999.
//   6 rst_n low for 1 cycle mid-slot while pending=1 -> an=1111 immediately; after
//     release the display shows 0000 and the pending load is never applied.

Source files
------------

// File: rtl/seg_display_scanner.sv
// +-----------------------------------------------------------------------------+
// | seg_display_scanner: multiplexes a 4-digit BCD value onto a common-anode    |
// | 7-segment display, with frame-synchronous value updates. Rev 1.0            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seg_display_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [3:0]  digit,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_done,
   output logic        bcd_err
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [19:0]      shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic [19:0]      disp_q, disp_d;
   logic             bcd_err_q, bcd_err_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       digit_q, digit_d;
   logic             dp_q, dp_d;
   logic             frame_done_q, frame_done_d;

   logic             tick;
   logic             boundary;
   logic [15:0]      disp_val;
   logic [3:0]       disp_dp;
   logic [3:0]       disp_bad;
   logic [3:0]       disp_zero;
   logic [3:0]       shadow_bad;
   logic [3:0]       lz_mask;
   logic [3:0]       slot_nib;
   logic             slot_bad;
   logic             slot_lz;
   logic             in_blank;

   assign disp_val = disp_q[19:4];
   assign disp_dp  = disp_q[3:0];

   // Shadow/display layout: {value[15:0], dp[3:0]}, so nibble i sits at [4+4i +: 4].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign disp_bad[gi]   = (disp_val[4*gi +: 4] > 4'd9);
         assign disp_zero[gi]  = (disp_val[4*gi +: 4] == 4'd0);
         assign shadow_bad[gi] = (shadow_q[4 + 4*gi +: 4] > 4'd9);
      end
   endgenerate

   // A digit is a leading zero only when it and every digit above it are zero.
   assign lz_mask[3] = disp_zero[3];
   assign lz_mask[2] = disp_zero[2] & lz_mask[3];
   assign lz_mask[1] = disp_zero[1] & lz_mask[2];
   assign lz_mask[0] = 1'b0;

   assign tick     = (cnt_q == CNT_MAX);
   assign boundary = tick && (idx_q == 2'd3);

   always_comb begin
      cnt_d        = tick ? '0 : cnt_q + CNT_ONE;
      idx_d        = tick ? idx_q + 2'd1 : idx_q;
      frame_done_d = boundary;
   end

   // A load coinciding with the boundary lands in shadow after disp has taken
   // the old shadow, so pending must survive that boundary.
   always_comb begin
      shadow_d  = load ? {value, dp_in} : shadow_q;
      pending_d = load | (pending_q & ~boundary);
      disp_d    = disp_q;
      bcd_err_d = bcd_err_q;
      if (boundary && pending_q) begin
         disp_d    = shadow_q;
         bcd_err_d = |shadow_bad;
      end
   end

   always_comb begin
      slot_nib = disp_val[{idx_q, 2'b00} +: 4];
      slot_bad = disp_bad[idx_q];
      slot_lz  = blank_lz & lz_mask[idx_q];
      in_blank = (cnt_q < BLANK_END);
      digit_d  = slot_bad ? 4'd0 : slot_nib;
      an_d     = 4'b1111;
      dp_d     = 1'b1;
      if (!in_blank) begin
         dp_d = ~disp_dp[idx_q];
         if (!(slot_bad || slot_lz)) begin
            an_d = ~(4'b0001 << idx_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         shadow_q     <= 20'd0;
         pending_q    <= 1'b0;
         disp_q       <= 20'd0;
         bcd_err_q    <= 1'b0;
         an_q         <= 4'b1111;
         digit_q      <= 4'd0;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         disp_q       <= disp_d;
         bcd_err_q    <= bcd_err_d;
         an_q         <= an_d;
         digit_q      <= digit_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digit      = digit_q;
   assign an         = an_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;
   assign bcd_err    = bcd_err_q;

endmodule

`default_nettype wire
